lockout_controller: RTL and testbench
=====================================

// Module: lockout_controller
// PURPOSE
//   Sequences the digital lock's timed phases. It decides, per completed code
//   entry, whether to open the lock for a fixed hold time or count a failure.
//   It enters a timed lockout after MAX_FAIL consecutive failures.
//   It owns its own 1 s prescaler and seconds down-counter and sits between the
//   keypad/compare logic and the door-actuator and display logic.
// PARAMETERS
//   CLK_FREQ  50_000_000  clk_50m cycles per second; prescaler terminal count is CLK_FREQ-1
//   MAX_FAIL  3           consecutive wrong codes that trigger lockout; legal range 1..7
//   LOCK_SEC  300         lockout duration in seconds; legal range 1..511
//   OPEN_SEC  5           unlock hold time in seconds; legal range 1..511
// PORTS
//   clk_50m     in   1  system clock
//   rst         in   1  asynchronous reset, active-high
//   code_valid  in   1  one-cycle pulse: a code entry has completed
//   code_ok     in   1  entered code matched; sampled only when code_valid=1
//   admin_clr   in   1  one-cycle pulse: abort any phase and clear the failure count
//   unlock      out  1  high while in OPEN
//   locked_out  out  1  high while in LOCKOUT
//   alarm       out  1  one-cycle pulse on entry to LOCKOUT
//   fail_cnt    out  3  consecutive failures, 0..MAX_FAIL
//   sec_left    out  9  seconds remaining in the current OPEN/LOCKOUT phase; 0 in IDLE
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE; all outputs 0; prescaler=0. Effective mid-phase.
//   - All outputs are registered. An input sampled at edge n is reflected in outputs after edge n.
//   - States and transitions:
//     * IDLE:
//       - code_valid & code_ok -> OPEN; fail_cnt<=0; sec_left<=OPEN_SEC.
//       - code_valid & !code_ok & fail_cnt+1<MAX_FAIL -> stay in IDLE; fail_cnt+1.
//       - code_valid & !code_ok & fail_cnt+1==MAX_FAIL -> LOCKOUT; fail_cnt<=MAX_FAIL;
//         sec_left<=LOCK_SEC; alarm=1 for exactly one cycle.
//     * OPEN: code_valid ignored, so the prescaler is not restarted.
//       On each tick sec_left decrements. On a tick with sec_left==1: sec_left<=0, go to IDLE.
//     * LOCKOUT: code_valid ignored (no fail_cnt change).
//       On a tick with sec_left==1: go to IDLE; fail_cnt<=0; sec_left<=0.
//   - admin_clr: from any state go to IDLE; fail_cnt<=0; sec_left<=0; alarm<=0.
//     Wins over a simultaneous code_valid or tick; that code entry is discarded.
//   - Prescaler:
//     * Clears to 0 on every entry to OPEN or LOCKOUT, so the first second is a full CLK_FREQ cycles.
//     * Counts 0..CLK_FREQ-1 only in OPEN/LOCKOUT and is held at 0 in IDLE.
//     * tick is internal, one cycle long, asserted at count==CLK_FREQ-1, then the count wraps to 0.
//     * Phase length is exactly SEC*CLK_FREQ cycles from the entry edge to the exit edge.
//   - Width rules:
//     * fail_cnt never exceeds MAX_FAIL and does not wrap.
//     * sec_left never underflows; no decrement occurs at 0.
//     * Prescaler width is $clog2(CLK_FREQ).
//   - Simultaneous tick with an ignored code_valid: the tick is processed normally.
// TESTING (CLK_FREQ=10, MAX_FAIL=3, LOCK_SEC=4, OPEN_SEC=2)
//   1 Correct code: code_valid=1 with code_ok=1 in IDLE -> next cycle unlock=1, sec_left=2.
//     10 cycles later sec_left=1; 20 cycles after entry unlock=0, sec_left=0.
//   2 Three wrong codes -> fail_cnt reads 1, then 2, then locked_out=1 with alarm high one cycle,
//     fail_cnt=3, sec_left=4. A correct code during lockout is ignored.
//     40 cycles after entry locked_out=0 and fail_cnt=0.
//   3 Failure counter cleared by success: wrong, wrong, correct -> fail_cnt goes 1, 2, then 0
//     with unlock=1; locked_out stays 0.
//   4 Admin clear collision: in LOCKOUT with sec_left=3, admin_clr and a correct code_valid
//     in the same cycle -> IDLE, unlock=0, locked_out=0, fail_cnt=0, sec_left=0.
//   5 Reset mid-phase: rst asserted mid-OPEN between clock edges -> unlock=0 and sec_left=0
//     immediately. After release a correct code reopens with the full 20-cycle hold.
//   6 Code during OPEN: code_valid (any code_ok) at OPEN cycle 5 -> no change.
//     unlock still falls exactly 20 cycles after entry.

Source files
------------

// File: rtl/lockout_controller.sv
// Lock phase sequencer: decides OPEN / failure count / LOCKOUT per completed code entry.
// Latency: every output is registered; an input sampled at edge n is visible just after edge n.
// Backpressure: none; code_valid pulses arriving during OPEN or LOCKOUT are discarded.
module lockout_controller #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_SEC = 300,
  parameter int OPEN_SEC = 5
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       code_valid,
  input  logic       code_ok,
  input  logic       admin_clr,
  output logic       unlock,
  output logic       locked_out,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [8:0] sec_left
);

  // A 1 Hz design (CLK_FREQ=1) still needs a 1-bit prescaler register.
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);
  localparam logic [3:0]    FAIL_LIM  = 4'(MAX_FAIL);
  localparam logic [8:0]    OPEN_S    = 9'(OPEN_SEC);
  localparam logic [8:0]    LOCK_S    = 9'(LOCK_SEC);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    fail_inc;

  // One-cycle second strobe; only meaningful while a timed phase is running.
  assign tick = (state != ST_IDLE) && (presc == PRESC_TC);

  // Failure count after this entry, widened so MAX_FAIL=7 cannot wrap the compare.
  assign fail_inc = {1'b0, fail_cnt} + 4'd1;

  // Phase FSM, prescaler and all registered outputs.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      alarm      <= 1'b0;
      fail_cnt   <= 3'd0;
      sec_left   <= 9'd0;
    end else begin
      // alarm is a strobe; only the LOCKOUT entry branch raises it.
      alarm <= 1'b0;

      if (admin_clr) begin
        // Abort beats any simultaneous code entry or tick.
        state      <= ST_IDLE;
        presc      <= '0;
        unlock     <= 1'b0;
        locked_out <= 1'b0;
        fail_cnt   <= 3'd0;
        sec_left   <= 9'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            presc <= '0;
            if (code_valid) begin
              if (code_ok) begin
                state    <= ST_OPEN;
                unlock   <= 1'b1;
                fail_cnt <= 3'd0;
                sec_left <= OPEN_S;
              end else if (fail_inc >= FAIL_LIM) begin
                state      <= ST_LOCKOUT;
                locked_out <= 1'b1;
                alarm      <= 1'b1;
                fail_cnt   <= FAIL_MAX;
                sec_left   <= LOCK_S;
              end else begin
                fail_cnt <= fail_inc[2:0];
              end
            end
          end

          ST_OPEN: begin
            if (tick) begin
              presc <= '0;
              if (sec_left == 9'd1) begin
                state    <= ST_IDLE;
                unlock   <= 1'b0;
                sec_left <= 9'd0;
              end else if (sec_left != 9'd0) begin
                sec_left <= sec_left - 9'd1;
              end
            end else begin
              presc <= presc + PRESC_ONE;
            end
          end

          ST_LOCKOUT: begin
            if (tick) begin
              presc <= '0;
              if (sec_left == 9'd1) begin
                state      <= ST_IDLE;
                locked_out <= 1'b0;
                fail_cnt   <= 3'd0;
                sec_left   <= 9'd0;
              end else if (sec_left != 9'd0) begin
                sec_left <= sec_left - 9'd1;
              end
            end else begin
              presc <= presc + PRESC_ONE;
            end
          end

          default: begin
            state      <= ST_IDLE;
            presc      <= '0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= 3'd0;
            sec_left   <= 9'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockout_controller.sv
// Bench for lockout_controller: directed scenarios plus randomized code entries.
// Latency: outputs compared on every falling edge against a phase/elapsed-time model.
// Backpressure: n/a; stimulus drives pulses freely.
module tb_lockout_controller;

  localparam int CF  = 10;
  localparam int MF  = 3;
  localparam int LS  = 4;
  localparam int OS  = 2;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic       code_ok = 1'b0;
  logic       admin_clr = 1'b0;
  logic       unlock;
  logic       locked_out;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic [8:0] sec_left;

  int n_checks = 0;
  int n_fail   = 0;

  lockout_controller #(
    .CLK_FREQ(CF),
    .MAX_FAIL(MF),
    .LOCK_SEC(LS),
    .OPEN_SEC(OS)
  ) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .code_valid(code_valid),
    .code_ok   (code_ok),
    .admin_clr (admin_clr),
    .unlock    (unlock),
    .locked_out(locked_out),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .sec_left  (sec_left)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase (0 idle, 1 open, 2 lockout), cycles elapsed since entry.
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_fail    = 0;
  int m_alarm   = 0;

  function automatic int phase_len(input int ph);
    return ((ph == 1) ? OS : LS) * CF;
  endfunction

  function automatic int m_sec_left();
    if (m_phase == 0) return 0;
    return ((m_phase == 1) ? OS : LS) - (m_elapsed / CF);
  endfunction

  // Advance the model once per clock using the inputs held across that edge.
  always @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_fail = 0; m_alarm = 0;
    end else if (admin_clr) begin
      m_phase = 0; m_elapsed = 0; m_fail = 0; m_alarm = 0;
    end else begin
      m_alarm = 0;
      if (m_phase == 0) begin
        if (code_valid) begin
          if (code_ok) begin
            m_phase = 1; m_elapsed = 0; m_fail = 0;
          end else if (m_fail + 1 >= MF) begin
            m_phase = 2; m_elapsed = 0; m_fail = MF; m_alarm = 1;
          end else begin
            m_fail = m_fail + 1;
          end
        end
      end else begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed >= phase_len(m_phase)) begin
          if (m_phase == 2) m_fail = 0;
          m_phase = 0;
          m_elapsed = 0;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk_50m) begin
    chk("cmp_unlock",     int'(unlock),     int'(m_phase == 1));
    chk("cmp_locked_out", int'(locked_out), int'(m_phase == 2));
    chk("cmp_alarm",      int'(alarm),      m_alarm);
    chk("cmp_fail_cnt",   int'(fail_cnt),   m_fail);
    chk("cmp_sec_left",   int'(sec_left),   m_sec_left());
  end

  // Called at a falling edge: present one code entry for exactly one rising edge.
  task automatic drive_code(input bit ok);
    code_valid = 1'b1;
    code_ok    = ok;
    @(negedge clk_50m);
    code_valid = 1'b0;
    code_ok    = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_unlock",   int'(unlock),     0);
    chk("rst_locked",   int'(locked_out), 0);
    chk("rst_alarm",    int'(alarm),      0);
    chk("rst_fail",     int'(fail_cnt),   0);
    chk("rst_sec",      int'(sec_left),   0);
    @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);

    // Correct code opens for exactly 20 cycles.
    drive_code(1'b1);
    chk("t1_unlock", int'(unlock), 1);
    chk("t1_sec2",   int'(sec_left), 2);
    repeat (9) @(negedge clk_50m);
    chk("t1_sec2_c9", int'(sec_left), 2);
    @(negedge clk_50m);
    chk("t1_sec1_c10", int'(sec_left), 1);
    repeat (9) @(negedge clk_50m);
    chk("t1_open_c19", int'(unlock), 1);
    @(negedge clk_50m);
    chk("t1_closed_c20", int'(unlock), 0);
    chk("t1_sec0_c20",   int'(sec_left), 0);

    // Three wrong codes lock out for 40 cycles; correct code ignored meanwhile.
    drive_code(1'b0);
    chk("t2_fail1", int'(fail_cnt), 1);
    drive_code(1'b0);
    chk("t2_fail2", int'(fail_cnt), 2);
    drive_code(1'b0);
    chk("t2_locked", int'(locked_out), 1);
    chk("t2_alarm",  int'(alarm), 1);
    chk("t2_fail3",  int'(fail_cnt), 3);
    chk("t2_sec4",   int'(sec_left), 4);
    @(negedge clk_50m);
    chk("t2_alarm_off", int'(alarm), 0);
    drive_code(1'b1);
    chk("t2_ignored_unlock", int'(unlock), 0);
    chk("t2_ignored_fail",   int'(fail_cnt), 3);
    repeat (37) @(negedge clk_50m);
    chk("t2_locked_c39", int'(locked_out), 1);
    @(negedge clk_50m);
    chk("t2_released_c40", int'(locked_out), 0);
    chk("t2_fail0_c40",    int'(fail_cnt), 0);

    // Success clears the failure count.
    drive_code(1'b0);
    chk("t3_fail1", int'(fail_cnt), 1);
    drive_code(1'b0);
    chk("t3_fail2", int'(fail_cnt), 2);
    drive_code(1'b1);
    chk("t3_fail0", int'(fail_cnt), 0);
    chk("t3_unlock", int'(unlock), 1);
    chk("t3_not_locked", int'(locked_out), 0);
    repeat (20) @(negedge clk_50m);

    // admin_clr collides with a correct code during LOCKOUT (sec_left=3).
    drive_code(1'b0);
    drive_code(1'b0);
    drive_code(1'b0);
    repeat (12) @(negedge clk_50m);
    chk("t4_sec3", int'(sec_left), 3);
    admin_clr  = 1'b1;
    code_valid = 1'b1;
    code_ok    = 1'b1;
    @(negedge clk_50m);
    admin_clr  = 1'b0;
    code_valid = 1'b0;
    code_ok    = 1'b0;
    chk("t4_unlock", int'(unlock), 0);
    chk("t4_locked", int'(locked_out), 0);
    chk("t4_fail",   int'(fail_cnt), 0);
    chk("t4_sec",    int'(sec_left), 0);

    // Asynchronous reset mid-OPEN, then a full-length reopen.
    drive_code(1'b1);
    repeat (5) @(negedge clk_50m);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_async_unlock", int'(unlock), 0);
    chk("t5_async_sec",    int'(sec_left), 0);
    @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    drive_code(1'b1);
    chk("t5_reopen_sec", int'(sec_left), 2);
    repeat (19) @(negedge clk_50m);
    chk("t5_open_c19", int'(unlock), 1);
    @(negedge clk_50m);
    chk("t5_closed_c20", int'(unlock), 0);

    // Code entry during OPEN does not disturb the hold time.
    drive_code(1'b1);
    repeat (4) @(negedge clk_50m);
    drive_code(1'b0);
    chk("t6_fail_unchanged", int'(fail_cnt), 0);
    chk("t6_sec_unchanged",  int'(sec_left), 2);
    repeat (14) @(negedge clk_50m);
    chk("t6_open_c19", int'(unlock), 1);
    @(negedge clk_50m);
    chk("t6_closed_c20", int'(unlock), 0);

    // Randomized entries, mostly wrong, with occasional admin clears.
    for (int i = 0; i < 3000; i++) begin
      code_valid = ($urandom_range(0, 3) == 0);
      code_ok    = ($urandom_range(0, 2) == 0);
      admin_clr  = ($urandom_range(0, 59) == 0);
      @(negedge clk_50m);
    end
    code_valid = 1'b0;
    code_ok    = 1'b0;
    admin_clr  = 1'b0;
    repeat (50) @(negedge clk_50m);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
